// File: rtl/exu_cal_mc_pkg.sv
// Shared definitions for the multi-cycle execute-stage calculation centre.
//   CAL_OP_W     : operation code width
//   cal_op_e     : operation codes (values 11..15 are illegal and return 0)
//   cal_state_e  : control FSM encoding
//   is_mul_op()  : true for opcodes handled by the iterative multiplier
package exu_cal_mc_pkg;

    localparam int unsigned CAL_OP_W = 4;

    typedef enum logic [CAL_OP_W-1:0] {
        CAL_ADD  = 4'd0,
        CAL_SUB  = 4'd1,
        CAL_AND  = 4'd2,
        CAL_OR   = 4'd3,
        CAL_XOR  = 4'd4,
        CAL_SLL  = 4'd5,
        CAL_SRL  = 4'd6,
        CAL_SRA  = 4'd7,
        CAL_CMP  = 4'd8,
        CAL_MUL  = 4'd9,
        CAL_MULH = 4'd10
    } cal_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } cal_state_e;

    function automatic logic is_mul_op(input logic [CAL_OP_W-1:0] op);
        return (op == CAL_MUL) || (op == CAL_MULH);
    endfunction

endpackage

// File: rtl/exu_cal_mc_if.sv
// Request/result handshake bundle between the ALU front-end and the
// calculation centre.
//   master : front-end side (drives request and result-ready)
//   slave  : calculation centre side (drives request-ready, result, busy)
interface exu_cal_mc_if
    import exu_cal_mc_pkg::*;
#(
    parameter int unsigned XLEN = 32
) ();

    logic                hs_al4cal_val;
    logic                hs_cal4al_rdy;
    logic [CAL_OP_W-1:0] i_op;
    logic                i_unsigned;
    logic [XLEN-1:0]     i_opn1;
    logic [XLEN-1:0]     i_opn2;
    logic                hs_cal4al_res_val;
    logic                hs_al4cal_res_rdy;
    logic [XLEN-1:0]     o_res;
    logic                o_busy;

    modport master (
        output hs_al4cal_val, i_op, i_unsigned, i_opn1, i_opn2, hs_al4cal_res_rdy,
        input  hs_cal4al_rdy, hs_cal4al_res_val, o_res, o_busy
    );

    modport slave (
        input  hs_al4cal_val, i_op, i_unsigned, i_opn1, i_opn2, hs_al4cal_res_rdy,
        output hs_cal4al_rdy, hs_cal4al_res_val, o_res, o_busy
    );

endinterface

// File: rtl/exu_cal_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_STEP multiplier bits per cycle.
//   clk, rst     : clock, asynchronous active-high reset
//   start        : latch operands and begin (ignored inputs afterwards)
//   signed_mode  : treat operands as two's complement (magnitude + sign)
//   opn1, opn2   : multiplicand, multiplier
//   done_c       : high during the final step; product_c is valid then
//   product_c    : full 2*XLEN product including sign fix-up
module exu_cal_mul_iter #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MUL_STEP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              signed_mode,
    input  logic [XLEN-1:0]   opn1,
    input  logic [XLEN-1:0]   opn2,
    output logic              done_c,
    output logic [2*XLEN-1:0] product_c
);

    localparam int unsigned PW    = 2 * XLEN;
    localparam int unsigned STEPS = XLEN / MUL_STEP;
    localparam int unsigned CNT_W = $clog2(STEPS);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             neg_q, neg_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [XLEN-1:0]  mplier_q, mplier_d;

    logic             neg1, neg2, last;
    logic [XLEN-1:0]  mag1, mag2;
    logic [PW-1:0]    sum;

    // Operand magnitudes; the product sign is recorded separately
    assign neg1 = signed_mode & opn1[XLEN-1];
    assign neg2 = signed_mode & opn2[XLEN-1];
    assign mag1 = neg1 ? (~opn1 + XLEN'(1)) : opn1;
    assign mag2 = neg2 ? (~opn2 + XLEN'(1)) : opn2;

    // Partial products for this step; multiplicand is pre-shifted by cnt*MUL_STEP
    always_comb begin
        sum = acc_q;
        for (int unsigned j = 0; j < MUL_STEP; j++) begin
            if (mplier_q[j]) begin
                sum = sum + (mcand_q << j);
            end
        end
    end

    assign last      = run_q && (cnt_q == CNT_W'(STEPS - 1));
    assign done_c    = last;
    assign product_c = neg_q ? (~sum + PW'(1)) : sum;

    // Next-state for the iteration registers
    always_comb begin
        cnt_d    = cnt_q;
        run_d    = run_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (start) begin
            run_d    = 1'b1;
            cnt_d    = '0;
            acc_d    = '0;
            neg_d    = neg1 ^ neg2;
            mcand_d  = PW'(mag1);
            mplier_d = mag2;
        end else if (run_q) begin
            acc_d    = sum;
            mcand_d  = mcand_q << MUL_STEP;
            mplier_d = mplier_q >> MUL_STEP;
            cnt_d    = cnt_q + CNT_W'(1);
            if (last) begin
                run_d = 1'b0;
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            run_q    <= 1'b0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            run_q    <= run_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

endmodule

// File: rtl/exu_cal_mc.sv
// Multi-cycle execute-stage calculation centre.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of exu_cal_mc_if
//              request  hs_al4cal_val / hs_cal4al_rdy with i_op, i_unsigned, i_opn1, i_opn2
//              result   hs_cal4al_res_val / hs_al4cal_res_rdy with o_res (registered)
//              o_busy   multiply iteration in progress
// Single-cycle ops complete in one cycle; MUL/MULH go through exu_cal_mul_iter.
module exu_cal_mc
    import exu_cal_mc_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MUL_STEP = 1
) (
    input  logic         clk,
    input  logic         rst,
    exu_cal_mc_if.slave  bus
);

    localparam int unsigned SHAMT_W = $clog2(XLEN);

    cal_state_e        state_q, state_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic              res_val_q, res_val_d;
    logic              busy_q, busy_d;
    logic              mulh_q, mulh_d;

    logic              rdy_c, accept_c, lt_c;
    logic              mul_start_c, mul_signed_c, mul_done_c;
    logic [2*XLEN-1:0] mul_prod_c;
    logic [XLEN-1:0]   alu_res_c;
    logic [SHAMT_W-1:0] shamt;

    // A new request can enter when idle, or when the held result retires this edge
    assign rdy_c    = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.hs_al4cal_res_rdy);
    assign accept_c = bus.hs_al4cal_val && rdy_c;

    assign shamt = bus.i_opn2[SHAMT_W-1:0];
    assign lt_c  = bus.i_unsigned ? (bus.i_opn1 < bus.i_opn2)
                                  : ($signed(bus.i_opn1) < $signed(bus.i_opn2));

    // Single-cycle datapath; illegal opcodes produce zero
    always_comb begin
        alu_res_c = '0;
        case (bus.i_op)
            CAL_ADD: alu_res_c = bus.i_opn1 + bus.i_opn2;
            CAL_SUB: alu_res_c = bus.i_opn1 - bus.i_opn2;
            CAL_AND: alu_res_c = bus.i_opn1 & bus.i_opn2;
            CAL_OR:  alu_res_c = bus.i_opn1 | bus.i_opn2;
            CAL_XOR: alu_res_c = bus.i_opn1 ^ bus.i_opn2;
            CAL_SLL: alu_res_c = bus.i_opn1 << shamt;
            CAL_SRL: alu_res_c = bus.i_opn1 >> shamt;
            CAL_SRA: alu_res_c = XLEN'($signed(bus.i_opn1) >>> shamt);
            CAL_CMP: alu_res_c = {{(XLEN-1){1'b0}}, lt_c};
            default: alu_res_c = '0;
        endcase
    end

    assign mul_signed_c = (bus.i_op == CAL_MULH) && !bus.i_unsigned;

    exu_cal_mul_iter #(
        .XLEN     (XLEN),
        .MUL_STEP (MUL_STEP)
    ) u_mul (
        .clk         (clk),
        .rst         (rst),
        .start       (mul_start_c),
        .signed_mode (mul_signed_c),
        .opn1        (bus.i_opn1),
        .opn2        (bus.i_opn2),
        .done_c      (mul_done_c),
        .product_c   (mul_prod_c)
    );

    // Control FSM: next state, result capture and multiplier launch
    always_comb begin
        state_d     = state_q;
        res_d       = res_q;
        mulh_d      = mulh_q;
        mul_start_c = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_c) begin
                    if (is_mul_op(bus.i_op)) begin
                        state_d     = ST_BUSY;
                        mul_start_c = 1'b1;
                        mulh_d      = (bus.i_op == CAL_MULH);
                    end else begin
                        state_d = ST_DONE;
                        res_d   = alu_res_c;
                    end
                end else if ((state_q == ST_DONE) && bus.hs_al4cal_res_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (mul_done_c) begin
                    state_d = ST_DONE;
                    res_d   = mulh_q ? mul_prod_c[2*XLEN-1:XLEN] : mul_prod_c[XLEN-1:0];
                end
            end
            default: state_d = ST_IDLE;
        endcase
        res_val_d = (state_d == ST_DONE);
        busy_d    = (state_d == ST_BUSY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            res_q     <= '0;
            res_val_q <= 1'b0;
            busy_q    <= 1'b0;
            mulh_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            res_q     <= res_d;
            res_val_q <= res_val_d;
            busy_q    <= busy_d;
            mulh_q    <= mulh_d;
        end
    end

    assign bus.hs_cal4al_rdy     = rdy_c;
    assign bus.hs_cal4al_res_val = res_val_q;
    assign bus.o_res             = res_q;
    assign bus.o_busy            = busy_q;

endmodule

// File: tb/tb_exu_cal_mc.sv
// Bench for exu_cal_mc: vector table plus hand sequences for multi-cycle cases,
// with a result scoreboard fed at accept and drained at retire.
module tb_exu_cal_mc;
    import exu_cal_mc_pkg::*;

    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exu_cal_mc_if #(.XLEN(XLEN)) bus  ();
    exu_cal_mc_if #(.XLEN(XLEN)) bus4 ();

    exu_cal_mc #(.XLEN(XLEN), .MUL_STEP(1)) dut  (.clk(clk), .rst(rst), .bus(bus));
    exu_cal_mc #(.XLEN(XLEN), .MUL_STEP(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    typedef struct {
        logic [3:0]  op;
        logic        uns;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb_q[$];
    logic [31:0] mon_exp;
    int          n_cmp;
    int          n_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic uns,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp);
        vec_t v;
        v.op = op; v.uns = uns; v.a = a; v.b = b; v.exp = exp;
        return v;
    endfunction

    // Retire monitor: every result handed over is matched against the scoreboard
    always @(negedge clk) begin
        if (!rst && bus.hs_cal4al_res_val && bus.hs_al4cal_res_rdy) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got %h, expected none", bus.o_res);
            end else begin
                mon_exp = sb_q.pop_front();
                check("result", bus.o_res, mon_exp);
            end
        end
    end

    // Present a request and hold it until accepted; leaves val asserted
    task automatic issue(input logic [3:0] op, input logic uns,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        bit ok;
        ok = 1'b0;
        bus.i_op = op; bus.i_unsigned = uns; bus.i_opn1 = a; bus.i_opn2 = b;
        bus.hs_al4cal_val = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (bus.hs_cal4al_rdy) begin
                sb_q.push_back(exp);
                ok = 1'b1;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got rdy=0 for 200 cycles, expected accept");
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        bus.hs_al4cal_val = 1'b0;
    endtask

    // Count cycles from the accept edge until res_val is seen
    task automatic wait_res(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.hs_cal4al_res_val && n < 200);
    endtask

    int   n;
    int   busy_n;
    logic rdy_seen;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        bus.hs_al4cal_val = 1'b0; bus.i_op = '0; bus.i_unsigned = 1'b0;
        bus.i_opn1 = '0; bus.i_opn2 = '0; bus.hs_al4cal_res_rdy = 1'b0;
        bus4.hs_al4cal_val = 1'b0; bus4.i_op = '0; bus4.i_unsigned = 1'b0;
        bus4.i_opn1 = '0; bus4.i_opn2 = '0; bus4.hs_al4cal_res_rdy = 1'b1;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_res_val", 32'(bus.hs_cal4al_res_val), 32'd0);
        check("rst_o_res",   bus.o_res,                  32'd0);
        check("rst_busy",    32'(bus.o_busy),            32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rdy_after_rst", 32'(bus.hs_cal4al_rdy), 32'd1);

        // ADD wrap, single-cycle latency
        bus.hs_al4cal_res_rdy = 1'b1;
        @(posedge clk); #1;
        issue(CAL_ADD, 1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);
        idle();
        wait_res(n);
        check("add_latency",   32'(n),                  32'd1);
        check("rdy_after_add", 32'(bus.hs_cal4al_rdy),  32'd1);
        @(posedge clk); #1;

        // Vector table, applied back-to-back
        vecs.push_back(mk(CAL_SUB,  1'b0, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE));
        vecs.push_back(mk(CAL_SRA,  1'b0, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000));
        vecs.push_back(mk(CAL_AND,  1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0));
        vecs.push_back(mk(CAL_OR,   1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0));
        vecs.push_back(mk(CAL_XOR,  1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00));
        vecs.push_back(mk(CAL_SLL,  1'b0, 32'h0000_0001, 32'h0000_003F, 32'h8000_0000));
        vecs.push_back(mk(CAL_SRL,  1'b0, 32'h8000_0000, 32'h0000_0021, 32'h4000_0000));
        vecs.push_back(mk(CAL_SRA,  1'b0, 32'h7FFF_FFFF, 32'h0000_001F, 32'h0000_0000));
        vecs.push_back(mk(CAL_CMP,  1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001));
        vecs.push_back(mk(CAL_CMP,  1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000));
        vecs.push_back(mk(CAL_CMP,  1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000));
        vecs.push_back(mk(CAL_MUL,  1'b0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780));
        vecs.push_back(mk(CAL_MUL,  1'b0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA));
        vecs.push_back(mk(CAL_MULH, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000));
        vecs.push_back(mk(CAL_MULH, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE));
        vecs.push_back(mk(CAL_MULH, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000));
        vecs.push_back(mk(CAL_MULH, 1'b0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF));
        vecs.push_back(mk(CAL_MULH, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000));
        vecs.push_back(mk(CAL_ADD,  1'b0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333));
        vecs.push_back(mk(4'hF,     1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0000));
        vecs.push_back(mk(4'hB,     1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0000));
        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i].op, vecs[i].uns, vecs[i].a, vecs[i].b, vecs[i].exp);
        end
        idle();
        for (int k = 0; k < 200 && sb_q.size() != 0; k++) begin
            @(negedge clk); #1;
        end
        check("table_drained", 32'(sb_q.size()), 32'd0);

        // MULH signed, MUL_STEP=1: busy window, refused requests, ignored input churn
        @(posedge clk); #1;
        bus.hs_al4cal_res_rdy = 1'b0;
        issue(CAL_MULH, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        bus.i_op = CAL_ADD;
        n = 0; busy_n = 0; rdy_seen = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (!bus.hs_cal4al_res_val) begin
                busy_n  += int'(bus.o_busy);
                rdy_seen = rdy_seen | bus.hs_cal4al_rdy;
                bus.i_opn1     = $urandom;
                bus.i_opn2     = $urandom;
                bus.i_op       = 4'($urandom_range(0, 10));
                bus.i_unsigned = 1'($urandom);
            end
        end while (!bus.hs_cal4al_res_val && n < 200);
        bus.hs_al4cal_val = 1'b0;
        check("mulh_latency",     32'(n),         32'd33);
        check("mulh_busy_cycles", 32'(busy_n),    32'd32);
        check("rdy_during_busy",  32'(rdy_seen),  32'd0);
        check("busy_when_done",   32'(bus.o_busy), 32'd0);
        @(posedge clk); #1;
        bus.hs_al4cal_res_rdy = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;

        // Same multiply with MUL_STEP=4
        bus4.i_op = CAL_MULH; bus4.i_unsigned = 1'b0;
        bus4.i_opn1 = 32'h8000_0000; bus4.i_opn2 = 32'h8000_0000;
        bus4.hs_al4cal_val = 1'b1;
        @(negedge clk);
        check("mul4_rdy", 32'(bus4.hs_cal4al_rdy), 32'd1);
        @(posedge clk); #1;
        bus4.hs_al4cal_val = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus4.hs_cal4al_res_val && n < 200);
        check("mul4_latency", 32'(n),     32'd9);
        check("mul4_o_res",   bus4.o_res, 32'h4000_0000);
        @(posedge clk); #1;

        // Backpressure: result held stable, new request refused until res_rdy
        bus.hs_al4cal_res_rdy = 1'b0;
        issue(CAL_MUL, 1'b0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780);
        bus.i_op = CAL_ADD; bus.i_opn1 = 32'd1; bus.i_opn2 = 32'd1;
        wait_res(n);
        check("mul_latency", 32'(n), 32'd33);
        for (int c = 0; c < 5; c++) begin
            check("bp_res_val", 32'(bus.hs_cal4al_res_val), 32'd1);
            check("bp_o_res",   bus.o_res,                   32'h2345_6780);
            check("bp_rdy",     32'(bus.hs_cal4al_rdy),      32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.hs_al4cal_res_rdy = 1'b1;
        issue(CAL_ADD, 1'b0, 32'd1, 32'd1, 32'd2);
        idle();
        wait_res(n);
        check("add_after_bp_latency", 32'(n), 32'd1);
        @(posedge clk); #1;

        // Reset in the middle of a multiply
        issue(CAL_MULH, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        idle();
        repeat (10) @(negedge clk);
        check("busy_before_rst", 32'(bus.o_busy), 32'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("midrst_res_val", 32'(bus.hs_cal4al_res_val), 32'd0);
        check("midrst_o_res",   bus.o_res,                   32'd0);
        check("midrst_busy",    32'(bus.o_busy),             32'd0);
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Illegal opcode after reset
        issue(4'hF, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0000);
        idle();
        wait_res(n);
        check("illegal_latency", 32'(n), 32'd1);
        @(posedge clk); #1;
        issue(CAL_SUB, 1'b0, 32'd10, 32'd3, 32'd7);
        idle();
        for (int k = 0; k < 200 && sb_q.size() != 0; k++) begin
            @(negedge clk); #1;
        end
        check("final_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/exu_cal_mc.md
Name: exu_cal_mc

Overview:
Multi-cycle, parametrised successor to the execute-stage calculation centre. Accepts one operation per handshake from the ALU front-end and produces a registered result on a separate valid/ready result channel. Single-cycle ops (add/sub/logic/shift/compare) complete in 1 cycle. Multiply runs as an iterative shift-add engine. Sits between exu_alu and the writeback mux; the result is held until it is consumed.

Parameters:
XLEN, 32, operand/result width (power of 2, >=8)
MUL_STEP, 1, multiplier bits retired per cycle (must divide XLEN; 1, 2 or 4)

Ports:
clk  input  1  core clock
rst  input  1  asynchronous, active-high reset
hs_al4cal_val  input  1  request valid
hs_cal4al_rdy  output  1  request ready
i_op  input  CAL_OP_W  operation code (package enum)
i_unsigned  input  1  1 = operands unsigned (CMP, MULH)
i_opn1  input  XLEN  operand 1
i_opn2  input  XLEN  operand 2 / shift amount
hs_cal4al_res_val  output  1  result valid
hs_al4cal_res_rdy  input  1  result ready
o_res  output  XLEN  result (registered)
o_busy  output  1  multiply iteration in progress

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE.
  - hs_cal4al_res_val=0, o_res=0, o_busy=0, iteration counter=0, accumulator=0.
  - hs_cal4al_rdy=1 after reset deasserts.
- A request is accepted when hs_al4cal_val & hs_cal4al_rdy.
- hs_cal4al_rdy = (state==IDLE) | (state==DONE & hs_al4cal_res_rdy). This gives back-to-back throughput of 1/cycle for single-cycle ops.
- FSM states:
  - IDLE:
    - accept single-cycle or illegal op -> DONE.
    - accept MUL/MULH -> BUSY.
    - no accept -> stay.
  - BUSY:
    - counter counts XLEN/MUL_STEP cycles.
    - on last step, result is loaded into o_res -> DONE.
    - requests are refused; o_busy=1.
  - DONE:
    - res_val=1; o_res is stable until res_rdy.
    - res_rdy & new accept -> DONE or BUSY per new op.
    - res_rdy & no accept -> IDLE.
    - !res_rdy -> hold.
- Latency (accept edge to res_val high): single-cycle ops 1 cycle; MUL/MULH XLEN/MUL_STEP+1 cycles.
- Operations (all results XLEN bits):
  - ADD, SUB: modulo 2^XLEN wrap, no flags.
  - AND, OR, XOR: bitwise.
  - SLL, SRL, SRA: amount = i_opn2[log2(XLEN)-1:0]; upper bits ignored.
  - CMP: 1 if opn1<opn2 (signed when i_unsigned=0), else 0.
  - MUL: low XLEN bits of product; signedness irrelevant.
  - MULH: high XLEN bits; signed x signed when i_unsigned=0, unsigned x unsigned when 1.
- Multiply engine:
  - Operands latched at accept; signed mode uses magnitudes plus a recorded sign.
  - 2*XLEN accumulator; each cycle adds multiplicand shifted by counter*MUL_STEP for each set multiplier bit.
  - Final two's-complement negate if the sign is set.
  - Input changes during BUSY have no effect.
- Illegal/unused opcode: accepted, result 0, latency 1 (no hang).
- Simultaneous res_rdy and val in DONE: the old result retires and the new one is captured in the same edge; no bubble, no lost result.
- Reset mid-BUSY or mid-DONE: the operation and result are discarded with no partial output; the next post-reset request is handled normally.
- Operands outside the handshake are don't-care; outputs never depend combinationally on i_opn*.

Decomposition:
- Package cirno9_cal_pkg (or `define block in cirno9_define.v) holds:
  - CAL_OP_W=4
  - op codes: CAL_ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, CMP=8, MUL=9, MULH=10
  - FSM state encoding: IDLE/BUSY/DONE
- One sub-module, exu_cal_mul_iter: the iterative multiplier datapath (counter, accumulator, sign fix-up) with start/done pulses. The top holds the FSM, single-cycle datapath and result register.

Test Plan:
- Reset then ADD 0xFFFFFFFF+0x00000002, res_rdy=1 -> res_val 1 cycle after accept, o_res=0x00000001; rdy high the next cycle.
- Back-to-back SUB 5-7, then SRA 0x80000000 by 0x24, res_rdy=1 -> results 0xFFFFFFFE then 0xF8000000 (amount 4) on consecutive cycles.
- CMP 0xFFFFFFFF vs 0x1 with i_unsigned=0 -> 1; with i_unsigned=1 -> 0.
- MULH signed 0x80000000 x 0x80000000, MUL_STEP=1:
  - o_busy=1 for 32 cycles; res_val at cycle 33; o_res=0x40000000.
  - rdy=0 throughout; inputs toggled during BUSY are ignored.
  - Repeat with MUL_STEP=4 -> res_val at cycle 9, same value.
- Backpressure: MUL 0x12345678 x 0x10 with res_rdy=0 for 5 cycles after done -> o_res=0x23456780 stable and res_val held; a new val is refused until res_rdy=1.
- Assert rst at BUSY cycle 10 -> res_val=0, o_res=0, o_busy=0 immediately. An illegal op (0xF) after reset -> o_res=0, latency 1.
